// File: rtl/alu_driver.sv
`default_nettype none
// ============================================================================
// Module   : alu_driver
// Brief    : Valid/ready sequencing front end for the 32-bit datapath ALU.
//            Decodes ALUOp/funct into the ALU select, drives registered
//            operands, captures SALU/ZF and returns them downstream.
//            Optional zero-flag consistency check: ALU_DRV_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_driver (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  aluop,
    input  logic [5:0]  funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic [2:0]  sel,
    input  logic [31:0] salu,
    input  logic        zf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        illegal,
    output logic [15:0] op_count,
    output logic        zf_mismatch
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_in_ready;
    logic        w_out_valid;
    logic        w_accept;
    logic        w_complete;
    logic [2:0]  w_dec_sel;
    logic        w_dec_illegal;

    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [2:0]  r_sel;
    logic        r_ill_pend;
    logic [31:0] r_result;
    logic        r_zero;
    logic        r_illegal;
    logic [15:0] r_op_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_accept    = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = EXEC;
                end
            end
            EXEC: begin
                w_next = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_complete = 1'b1;
                    w_next     = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Unsupported R-type functs select 111, which the ALU answers with zero.
    always_comb begin
        w_dec_sel     = 3'b111;
        w_dec_illegal = 1'b0;
        case (aluop)
            2'b00: w_dec_sel = 3'b010;
            2'b01: w_dec_sel = 3'b011;
            2'b11: w_dec_sel = 3'b101;
            default: begin
                case (funct)
                    6'b100100: w_dec_sel = 3'b000;
                    6'b100101: w_dec_sel = 3'b001;
                    6'b100000: w_dec_sel = 3'b010;
                    6'b100010: w_dec_sel = 3'b011;
                    6'b101010: w_dec_sel = 3'b100;
                    default: begin
                        w_dec_sel     = 3'b111;
                        w_dec_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op1      <= 32'd0;
            r_op2      <= 32'd0;
            r_sel      <= 3'b000;
            r_ill_pend <= 1'b0;
            r_result   <= 32'd0;
            r_zero     <= 1'b0;
            r_illegal  <= 1'b0;
            r_op_count <= 16'd0;
        end else begin
            if (w_accept) begin
                r_op1      <= a;
                r_op2      <= b;
                r_sel      <= w_dec_sel;
                r_ill_pend <= w_dec_illegal;
            end
            if (r_state == EXEC) begin
                r_result  <= salu;
                r_zero    <= zf;
                r_illegal <= r_ill_pend;
            end
            if (w_complete) begin
                r_op_count <= r_op_count + 16'd1;
            end
        end
    end

`ifdef ALU_DRV_CHECK_EN
    logic r_zf_mismatch;

    // Sticky until reset so a single glitch in the ALU flag is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zf_mismatch <= 1'b0;
        end else if ((r_state == EXEC) && (zf != (salu == 32'd0))) begin
            r_zf_mismatch <= 1'b1;
        end
    end

    assign zf_mismatch = r_zf_mismatch;
`else
    assign zf_mismatch = 1'b0;
`endif

    assign in_ready  = w_in_ready & ~rst;
    assign out_valid = w_out_valid;
    assign op1       = r_op1;
    assign op2       = r_op2;
    assign sel       = r_sel;
    assign result    = r_result;
    assign zero      = r_zero;
    assign illegal   = r_illegal;
    assign op_count  = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_driver
// Brief    : Randomized self-checking bench for alu_driver with a stub ALU and
//            a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_driver;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  sel;
    logic [31:0] salu;
    logic        zf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic [15:0] op_count;
    logic        zf_mismatch;

    int          n_cmp;
    int          n_err;
    logic [15:0] m_count;
    logic        m_mm;
    logic        corrupt;

    alu_driver dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .aluop      (aluop),
        .funct      (funct),
        .a          (a),
        .b          (b),
        .op1        (op1),
        .op2        (op2),
        .sel        (sel),
        .salu       (salu),
        .zf         (zf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .illegal    (illegal),
        .op_count   (op_count),
        .zf_mismatch(zf_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [2:0] s, input logic [31:0] x, input logic [31:0] y);
        case (s)
            3'b000:  return x & y;
            3'b001:  return x | y;
            3'b010:  return x + y;
            3'b011:  return x - y;
            3'b100:  return (x < y) ? 32'd1 : 32'd0;
            3'b101:  return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    // Stub ALU; 'corrupt' forces an inconsistent zero flag.
    always_comb begin
        salu = alu_ref(sel, op1, op2);
        zf   = (salu == 32'd0);
        if (corrupt) begin
            salu = 32'd3;
            zf   = 1'b1;
        end
    end

    // Returns {illegal, sel}.
    function automatic logic [3:0] decode_ref(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0011;
        if (op == 2'b11) return 4'b0101;
        case (fn)
            6'd36:   return 4'b0000;
            6'd37:   return 4'b0001;
            6'd32:   return 4'b0010;
            6'd34:   return 4'b0011;
            6'd42:   return 4'b0100;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_txn(input logic [1:0] op, input logic [5:0] fn,
                          input logic [31:0] x, input logic [31:0] y, input int hold);
        logic [3:0]  d;
        logic [31:0] e_res;
        logic        e_zero;
        int          t;
        d      = decode_ref(op, fn);
        e_res  = corrupt ? 32'd3 : alu_ref(d[2:0], x, y);
        e_zero = corrupt ? 1'b1 : (e_res == 32'd0);
        @(negedge clk);
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        aluop    = op;
        funct    = fn;
        a        = x;
        b        = y;
        @(negedge clk);
        in_valid  = 1'b0;
        aluop     = 2'($urandom);
        funct     = 6'($urandom);
        a         = $urandom;
        b         = $urandom;
        out_ready = 1'($urandom);
        check("exec_sel", {29'd0, sel}, {29'd0, d[2:0]});
        check("exec_op1", op1, x);
        check("exec_op2", op2, y);
        check("exec_in_ready", {31'd0, in_ready}, 32'd0);
        check("exec_out_valid", {31'd0, out_valid}, 32'd0);
`ifdef ALU_DRV_CHECK_EN
        if (corrupt) m_mm = 1'b1;
`endif
        @(negedge clk);
        out_ready = (hold == 0);
        in_valid  = (hold != 0);
        check("done_out_valid", {31'd0, out_valid}, 32'd1);
        check("done_result", result, e_res);
        check("done_zero", {31'd0, zero}, {31'd0, e_zero});
        check("done_illegal", {31'd0, illegal}, {31'd0, d[3]});
        check("zf_mismatch", {31'd0, zf_mismatch}, {31'd0, m_mm});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_result", result, e_res);
            check("hold_zero", {31'd0, zero}, {31'd0, e_zero});
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_op_count", {16'd0, op_count}, {16'd0, m_count});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        m_count   = m_count + 16'd1;
        check("post_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_in_ready", {31'd0, in_ready}, 32'd1);
        check("op_count", {16'd0, op_count}, {16'd0, m_count});
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        m_count   = 16'd0;
        m_mm      = 1'b0;
        corrupt   = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        aluop     = 2'b00;
        funct     = 6'd0;
        a         = 32'd0;
        b         = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_op_count", {16'd0, op_count}, 32'd0);
        check("rst_sel", {29'd0, sel}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zf_mismatch", {31'd0, zf_mismatch}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        do_txn(2'b10, 6'b100000, 32'd5, 32'd7, 0);
        do_txn(2'b01, 6'd0, 32'h1234, 32'h1234, 5);
        do_txn(2'b10, 6'b000111, 32'hdead, 32'hbeef, 1);
        do_txn(2'b10, 6'b101010, 32'd3, 32'd9, 0);
        do_txn(2'b11, 6'd0, 32'd0, 32'd0, 0);
        do_txn(2'b00, 6'd0, 32'hffff_ffff, 32'd1, 2);

        // Back-to-back: four requests in twelve edges.
        @(negedge clk);
        in_valid  = 1'b1;
        aluop     = 2'b00;
        a         = 32'd1;
        b         = 32'd2;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        m_count   = m_count + 16'd4;
        check("b2b_op_count", {16'd0, op_count}, {16'd0, m_count});
        check("b2b_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset while in EXEC drops the transaction.
        @(negedge clk);
        in_valid = 1'b1;
        aluop    = 2'b10;
        funct    = 6'b100000;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        m_count = 16'd0;
        m_mm    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        check("midrst_op_count", {16'd0, op_count}, 32'd0);
        check("midrst_idle", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 40; i++) begin
            logic [5:0] fn;
            case ($urandom_range(0, 5))
                0: fn = 6'd36;
                1: fn = 6'd37;
                2: fn = 6'd32;
                3: fn = 6'd34;
                4: fn = 6'd42;
                default: fn = 6'($urandom);
            endcase
            do_txn(2'($urandom), fn, $urandom, ($urandom_range(0, 3) == 0) ? 32'd7 : $urandom,
                   int'($urandom_range(0, 2)));
        end

        // Counter wrap: preload the count register directly while idle.
        @(negedge clk);
        dut.r_op_count = 16'hffff;
        m_count        = 16'hffff;
        do_txn(2'b10, 6'b100101, 32'hf0, 32'h0f, 0);
        check("wrap_op_count", {16'd0, op_count}, 32'd0);

        corrupt = 1'b1;
        do_txn(2'b00, 6'd0, 32'd1, 32'd1, 0);
        corrupt = 1'b0;
        do_txn(2'b00, 6'd0, 32'd2, 32'd2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
